// File: rtl/float_conv_pkg.sv
// Shared constants and types for the single-precision float to unsigned 8-bit converter.
package float_conv_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int INT_W    = 8;

  typedef enum logic [2:0] {
    ZERO,
    NORMAL,
    NEG,
    POS_INF,
    NAN
  } f_class_e;

  // value carries one spare bit so an already-too-large exponent reaches S2 as 256
  typedef struct packed {
    logic [INT_W:0] value;
    logic           guard;
    logic           sticky;
    f_class_e       cls;
  } s1_reg_t;

endpackage

// File: rtl/f2i_round_sat.sv
// Combinational round-half-to-even and clamp to 0..255 with result flags.
module f2i_round_sat
  import float_conv_pkg::*;
(
  input  s1_reg_t          s1,
  output logic [INT_W-1:0] result,
  output logic             flag_sat,
  output logic             flag_neg,
  output logic             flag_nan
);

  localparam logic [INT_W+1:0] MAX_U = (INT_W+2)'((1 << INT_W) - 1);

  function automatic logic [INT_W+1:0] round_half_even(input logic [INT_W:0] v,
                                                       input logic g,
                                                       input logic s);
    logic up;
    up = g & (s | v[0]);
    return {1'b0, v} + {{(INT_W+1){1'b0}}, up};
  endfunction

  // returns {saturated, clamped value}
  function automatic logic [INT_W:0] saturate(input logic [INT_W+1:0] r);
    if (r > MAX_U)
      return {1'b1, {INT_W{1'b1}}};
    return {1'b0, r[INT_W-1:0]};
  endfunction

  logic [INT_W+1:0] rounded;
  logic [INT_W:0]   clamped;

  always_comb begin
    rounded  = round_half_even(s1.value, s1.guard, s1.sticky);
    clamped  = saturate(rounded);
    result   = '0;
    flag_sat = 1'b0;
    flag_neg = 1'b0;
    flag_nan = 1'b0;
    case (s1.cls)
      NAN:     flag_nan = 1'b1;
      POS_INF: begin
        result   = {INT_W{1'b1}};
        flag_sat = 1'b1;
      end
      NEG:     flag_neg = 1'b1;
      NORMAL:  begin
        result   = clamped[INT_W-1:0];
        flag_sat = clamped[INT_W];
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/float_to_int.sv
// Two-stage float32 to unsigned 8-bit converter with valid/ready handshakes on both sides.
module float_to_int
  import float_conv_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXP_W+MAN_W:0]       float_input,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INT_W-1:0]           int_output,
  output logic                       flag_sat,
  output logic                       flag_neg,
  output logic                       flag_nan
);

  localparam logic signed [EXP_W+1:0] E_OVF = (EXP_W+2)'(INT_W);
  localparam logic signed [EXP_W+1:0] E_MIN = -(EXP_W+2)'(1);

  logic                      sign_p0;
  logic [EXP_W-1:0]          exp_p0;
  logic [MAN_W-1:0]          man_p0;
  logic signed [EXP_W+1:0]   e_p0;
  logic [3:0]                shamt_p0;
  logic [MAN_W+INT_W+1:0]    wide_p0;
  s1_reg_t                   s1_p0;

  s1_reg_t                   s1_p1;
  logic                      vld_p1;
  logic [INT_W-1:0]          res_p1;
  logic                      sat_p1;
  logic                      neg_p1;
  logic                      nan_p1;

  logic                      vld_p2;
  logic                      s1_load;
  logic                      s2_load;

  assign s2_load   = !vld_p2 || out_ready;
  assign s1_load   = !vld_p1 || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = vld_p2;

  // Stage 0 -> 1: classify and align {1,m} so the integer part lands in wide_p0[32:24]
  assign {sign_p0, exp_p0, man_p0} = float_input;
  assign e_p0     = $signed({2'b00, exp_p0}) - $signed((EXP_W+2)'(EXP_BIAS));
  assign shamt_p0 = 4'((EXP_W+2)'(INT_W - 1) - e_p0);
  assign wide_p0  = {1'b0, 1'b1, man_p0, {INT_W{1'b0}}} >> shamt_p0;

  always_comb begin
    s1_p0 = '0;
    if (exp_p0 == '1 && man_p0 != '0) begin
      s1_p0.cls = NAN;
    end else if (exp_p0 == '1 && !sign_p0) begin
      s1_p0.cls = POS_INF;
    end else if (sign_p0 && (exp_p0 != '0 || man_p0 != '0)) begin
      s1_p0.cls = NEG;
    end else if (exp_p0 == '0) begin
      s1_p0.cls = ZERO;
    end else begin
      s1_p0.cls = NORMAL;
      if (e_p0 >= E_OVF) begin
        s1_p0.value = {1'b1, {INT_W{1'b0}}};
      end else if (e_p0 >= E_MIN) begin
        s1_p0.value  = wide_p0[MAN_W+INT_W+1:MAN_W+1];
        s1_p0.guard  = wide_p0[MAN_W];
        s1_p0.sticky = |wide_p0[MAN_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load && in_valid)
      s1_p1 <= s1_p0;
  end

  // Stage 1 -> 2: round, saturate and register the result
  f2i_round_sat u_round_sat (
    .s1       (s1_p1),
    .result   (res_p1),
    .flag_sat (sat_p1),
    .flag_neg (neg_p1),
    .flag_nan (nan_p1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      int_output <= '0;
      flag_sat   <= 1'b0;
      flag_neg   <= 1'b0;
      flag_nan   <= 1'b0;
    end else begin
      if (s1_load)
        vld_p1 <= in_valid;
      if (s2_load) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          int_output <= res_p1;
          flag_sat   <= sat_p1;
          flag_neg   <= neg_p1;
          flag_nan   <= nan_p1;
        end
      end
    end
  end

endmodule

// File: tb/tb_float_to_int.sv
// Scoreboard bench for float_to_int: directed corner cases, backpressure, reset flush, random traffic.
module tb_float_to_int;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] float_input;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  int_output;
  logic        flag_sat;
  logic        flag_neg;
  logic        flag_nan;

  always #5 clk = ~clk;

  float_to_int dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .float_input (float_input),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .int_output  (int_output),
    .flag_sat    (flag_sat),
    .flag_neg    (flag_neg),
    .flag_nan    (flag_nan)
  );

  typedef struct {
    logic [10:0] v;
    int          acc;
    bit          chk_lat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          lat_mode = 1'b0;
  bit          rand_ready = 1'b0;
  bit          hold_vld = 1'b0;
  logic [10:0] hold_v;
  logic [31:0] specials [9] = '{32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h00000000,
                                32'h80000000, 32'h00000005, 32'h80000005, 32'h4B800000,
                                32'h437FFFFF};

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact quotient/remainder of the significand against 2^(23-E), ties to even.
  // Result packed as {value[7:0], sat, neg, nan}.
  function automatic logic [10:0] model(input logic [31:0] f);
    int     ex;
    int     e;
    int     sh;
    longint sig;
    longint q;
    longint r;
    longint half;
    ex = int'(f[30:23]);
    if (ex == 255 && f[22:0] != 0) return {8'd0, 3'b001};
    if (ex == 255 && !f[31])       return {8'd255, 3'b100};
    if (f[31] && f[30:0] != 0)     return {8'd0, 3'b010};
    if (ex == 0)                   return 11'd0;
    e = ex - 127;
    if (e < -1) return 11'd0;
    if (e >= 8) return {8'd255, 3'b100};
    sig  = longint'({1'b1, f[22:0]});
    sh   = 23 - e;
    q    = sig >> sh;
    r    = sig - (q << sh);
    half = longint'(1) << (sh - 1);
    if (r > half || (r == half && q[0])) q = q + 1;
    if (q > 255) return {8'd255, 3'b100};
    return {q[7:0], 3'b000};
  endfunction

  function automatic logic [31:0] rand_float();
    int          k;
    logic [31:0] f;
    k = $urandom_range(0, 9);
    f = $urandom;
    if (k <= 5) begin
      f[30:23] = 8'($urandom_range(124, 136));
      f[31]    = ($urandom_range(0, 7) == 0);
    end else if (k == 6) begin
      f[30:23] = 8'($urandom_range(126, 134));
      f[31]    = 1'b0;
      f[22:0]  = f[22:0] & 23'h7F0000;
    end else if (k == 7) begin
      f = specials[$urandom_range(0, 8)];
    end
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic send(input logic [31:0] f);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    in_valid = 1'b1;
    float_input = f;
    while (!done && n < 200) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{v: model(f), acc: cyc, chk_lat: lat_mode});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted input=%h", f);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops the scoreboard on each transfer, and checks outputs hold while stalled.
  always @(negedge clk) begin
    if (rst) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld)
        chk("hold", 32'({out_valid, int_output, flag_sat, flag_neg, flag_nan}), 32'({1'b1, hold_v}));
      hold_vld = out_valid && !out_ready;
      hold_v   = {int_output, flag_sat, flag_neg, flag_nan};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0h required=no_output",
                   {int_output, flag_sat, flag_neg, flag_nan});
        end else begin
          mon_e = exp_q.pop_front();
          chk("result", 32'({int_output, flag_sat, flag_neg, flag_nan}), 32'(mon_e.v));
          chk("flag_onehot", 32'($onehot0({flag_sat, flag_neg, flag_nan})), 32'd1);
          if (mon_e.chk_lat)
            chk("latency", 32'(cyc - mon_e.acc), 32'd2);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    float_input = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_int_output", 32'(int_output), 32'd0);
    chk("rst_flags", 32'({flag_sat, flag_neg, flag_nan}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // back-to-back with latency checked
    out_ready = 1'b1;
    lat_mode = 1'b1;
    send(32'h437F0000);
    send(32'h43000000);
    send(32'h3FC00000);
    idle(4);

    // ties, near-ties and specials
    send(32'h3F000000);
    send(32'h40200000);
    send(32'h431E8000);
    send(32'h437E8000);
    send(32'h437F8000);
    send(32'h40600000);
    send(32'h3F000001);
    send(32'h3EFFFFFF);
    send(32'h3F800000);
    send(32'h7FC00000);
    send(32'h7F800000);
    send(32'hBF800000);
    send(32'h80000000);
    send(32'h00000001);
    send(32'h4B800000);
    idle(4);
    lat_mode = 1'b0;

    // backpressure: two accepted, third refused until downstream drains
    out_ready = 1'b0;
    send(32'h42280000);
    send(32'h41200000);
    chk("bp_accepted", 32'(exp_q.size()), 32'd2);
    in_valid = 1'b1;
    float_input = 32'h40400000;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(32'h40400000);
    idle(5);

    // reset with both stages full
    out_ready = 1'b0;
    send(32'h42C80000);
    send(32'h42CA0000);
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_int_output", 32'(int_output), 32'd0);
    chk("mid_rst_flags", 32'({flag_sat, flag_neg, flag_nan}), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(6);

    // random traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(rand_float());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_ready = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_to_int.md
FLOAT_TO_INT -- requirements
Module: float_to_int

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (8-bit integer output, IEEE 754 single-precision input).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  float_input is valid this cycle.
REQ-005 in_ready  output  1  the block accepts float_input this cycle.
REQ-006 float_input  input  32  IEEE 754 single-precision value to convert.
REQ-007 out_valid  output  1  int_output and the flags hold a result.
REQ-008 out_ready  input  1  downstream consumes the result this cycle.
REQ-009 int_output  output  8  unsigned result, range 0..255.
REQ-010 flag_sat  output  1  result clamped to 255 because the rounded value exceeded 255, or the input was +inf.
REQ-011 flag_neg  output  1  the input was negative and nonzero (not -0, not NaN); result forced to 0.
REQ-012 flag_nan  output  1  the input was NaN (exponent 255, mantissa nonzero); result forced to 0.

Function
REQ-013 A transfer SHALL occur on an edge where in_valid and in_ready are both high; a result is consumed where out_valid and out_ready are both high.
REQ-014 The datapath SHALL be a 2-stage pipeline:
- S1: classify, then align the mantissa with the implicit 1.
- S2: round, then saturate.
- Latency from accept to out_valid is exactly 2 cycles when there is no stall.
REQ-015 S2 SHALL load when out_valid is low or out_ready is high.
REQ-016 S1 SHALL load when S1 is empty or S2 loads.
REQ-017 in_ready SHALL equal (S1 empty) OR (S2 loads); it is combinational with no dependence on in_valid.
REQ-018 With out_ready held high, the block SHALL sustain one result per cycle.
REQ-019 While out_valid is high and out_ready is low, int_output and all flags SHALL hold stable.
REQ-020 Decode: E = exp - 127. Cases in priority order:
- NaN -> 0, flag_nan.
- +inf -> 255, flag_sat.
- -inf or any negative nonzero value -> 0, flag_neg.
- exp = 0 (zero or denormal, either sign) -> 0, no flags.
REQ-021 Positive normal inputs:
- E < -1 -> 0.
- E >= 8 -> 255 with flag_sat.
- Otherwise the integer part is {1,m} shifted right by (23 - E), and the discarded bits form guard and sticky.
REQ-022 Rounding SHALL be round-half-to-even: round up if guard=1 and (sticky=1 or integer LSB=1).
REQ-023 A rounded result of 256 SHALL saturate to 255 with flag_sat.
REQ-024 At most one flag SHALL be high per result.
REQ-025 Outside a valid result, int_output and the flags are don't-care but SHALL be driven (no X).

Reset
REQ-026 While rst is high at an edge, both stage valid bits SHALL clear and out_valid = 0.
REQ-027 While rst is high at an edge, int_output = 0 and flag_sat = flag_neg = flag_nan = 0.
REQ-028 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight data, and no result from before reset SHALL appear afterwards.

Structure
REQ-030 Package float_conv_pkg SHALL hold:
- constants EXP_BIAS=127, EXP_W=8, MAN_W=23, INT_W=8;
- a packed struct for the S1->S2 register (value, guard, sticky, class);
- an enum for the input class: ZERO, NORMAL, NEG, POS_INF, NAN.
REQ-031 The round/saturate logic SHALL be one combinational sub-module, f2i_round_sat, instantiated in S2; the pipeline control stays in float_to_int.

Verification
REQ-032 Back-to-back inputs 0x437F0000, 0x43000000, 0x3FC00000 with out_ready=1 -> outputs 255, 128, 2 on consecutive cycles, first one 2 cycles after accept, no flags.
REQ-033 Ties: 0x3F000000 (0.5) -> 0; 0x40200000 (2.5) -> 2; 0x431E8000 (158.5) -> 158; 0x437E8000 (254.5) -> 254; 0x437F8000 (255.5) -> 255 with flag_sat.
REQ-034 Specials: 0x7FC00000 -> 0, flag_nan; 0x7F800000 -> 255, flag_sat; 0xBF800000 -> 0, flag_neg; 0x80000000 -> 0, no flags; 0x00000001 -> 0, no flags; 0x4B800000 -> 255, flag_sat.
REQ-035 Backpressure: out_ready=0 while 3 inputs are offered -> 2 accepted, then in_ready=0; outputs hold stable. Then out_ready=1 -> results drain in order with none lost or duplicated.
REQ-036 Reset mid-operation: rst pulsed one cycle with both stages full -> next cycle out_valid=0, outputs 0, in_ready=1; no stale result emerges afterwards.
